rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Write-back arbiter for the 16x16-bit RegisterFile, which has one write port (dstReg/dstData/writeReg).
//  Two producers compete for that port: the ALU and the memory/load unit.
//  Each producer has a small FIFO buffer. The block grants the port once per cycle and drives a registered write.
//  It also exports a pending-write mask that the decode stage uses for hazard stalls.
// PARAMETERS
//  DEPTH       2   entries per producer FIFO (power of two, >=2)
//  STARVE_MAX  3   consecutive lost arbitrations after which ALU wins over MEM
// PORTS
//  clk        in   1   rising-edge clock, the only clock
//  rst        in   1   asynchronous active-low reset
//  flush      in   1   synchronous: discard all buffered writes
//  alu_valid  in   1   ALU write request
//  alu_ready  out  1   ALU FIFO can accept (= !alu_full)
//  alu_reg    in   4   ALU destination register
//  alu_data   in   16  ALU write data
//  mem_valid  in   1   MEM write request
//  mem_ready  out  1   MEM FIFO can accept (= !mem_full)
//  mem_reg    in   4   MEM destination register
//  mem_data   in   16  MEM write data
//  writeReg   out  1   RegisterFile write enable (registered)
//  dstReg     out  4   RegisterFile write address (registered)
//  dstData    out  16  RegisterFile write data (registered)
//  pend_mask  out  16  bit r = 1: a write to register r is buffered or currently issuing
//  busy       out  1   |pend_mask
// BEHAVIOUR
//  Reset (rst=0, async):
//   - FIFOs are emptied, starve_cnt=0, writeReg=0, dstReg=0, dstData=0.
//   - pend_mask=0, busy=0, alu_ready=mem_ready=1.
//   - This applies mid-burst too: in-flight writes are lost and writeReg drops immediately.
//  Accept: push on a rising edge when x_valid & x_ready. ready depends only on full, never on valid.
//   - A full FIFO does not accept, even if it pops in the same cycle (no pass-through).
//  Arbitrate: every cycle, look at the FIFO heads.
//   - Neither FIFO non-empty: no grant.
//   - Only one non-empty: grant it.
//   - Both non-empty: grant MEM, unless starve_cnt==STARVE_MAX, then grant ALU.
//   - starve_cnt: +1 when ALU loses to MEM; reset to 0 when ALU is granted or the ALU FIFO is empty.
//   - The granted head pops on the same edge that loads the output stage.
//  Output stage:
//   - writeReg<=grant, dstReg/dstData<=granted head. With no grant, writeReg<=0 and dstReg/dstData hold.
//   - Latency: a request accepted at edge N appears on the write port in cycle N+1 at the earliest.
//     The RegisterFile captures it at edge N+2.
//   - Throughput: one write per cycle sustained.
//  pend_mask: combinational OR of one-hot(reg) over all valid FIFO entries and the output stage when writeReg=1.
//  Ordering:
//   - Writes from the same producer retire in FIFO order.
//   - Across producers there is no ordering. Decode must not issue a write to register r while pend_mask[r]=1.
//  flush:
//   - Next edge: both FIFOs empty, writeReg=0, starve_cnt=0.
//   - Pushes in the flush cycle are dropped.
//   - A write already issuing in the flush cycle still completes.
//  Registers 0..15 are all writable; this block applies no address filtering.
// STRUCTURE
//  Shared package rf_pkg: RF_ADDR_W=4, RF_DATA_W=16, RF_NUM_REGS=16, and a wb_req struct {reg, data}.
//  Sub-module rf_wb_fifo (DEPTH, push/pop/full/empty/head, per-entry valid+reg vector for pend_mask).
//   - Instantiated twice.
//  Top level: arbiter, starve_cnt, output register, pend_mask OR tree.
// TESTING
//  1. Reset mid-operation:
//     - Stimulus: both FIFOs full, writeReg=1; pull rst low between edges.
//     - Required: writeReg=0, pend_mask=0, ready=1 immediately; no write after rst returns high.
//  2. Single ALU write:
//     - Stimulus: alu_reg=3, alu_data=16'hBEEF accepted at edge N.
//     - Required: in cycle N+1, writeReg=1, dstReg=3, dstData=BEEF, pend_mask=16'h0008. Cycle N+2: pend_mask=0.
//  3. Starvation:
//     - Stimulus: both producers valid every cycle.
//     - Required: grant pattern MEM,MEM,MEM,ALU repeating; no cycle with writeReg=0 once both FIFOs are filled.
//  4. Backpressure:
//     - Stimulus: MEM valid continuously, ALU pushes 4 writes.
//     - Required: alu_ready falls after the 2nd ALU push; all 4 ALU writes appear, in order, with correct data.
//  5. Flush:
//     - Stimulus: ALU holds reg 5, MEM holds reg 9; assert flush for 1 cycle.
//     - Required: pend_mask=0 next cycle, and no write to reg 5 or 9 ever appears.
//  6. Same-cycle push to an empty FIFO while the other FIFO is empty.
//     - Required: write issues exactly 1 cycle later. Also an idle cycle gives writeReg=0 with dstReg held.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file write-back types: address/data widths and the write request record.
// Latency: none (types and a combinational helper only).
// Backpressure: not applicable.
package rf_pkg;

    localparam int RF_ADDR_W   = 4;
    localparam int RF_DATA_W   = 16;
    localparam int RF_NUM_REGS = 16;

    // One buffered register-file write: destination register and write data.
    typedef struct packed {
        logic [RF_ADDR_W-1:0] dst;
        logic [RF_DATA_W-1:0] data;
    } wb_req;

    // One-hot decode of a register number, used to build hazard masks.
    function automatic logic [RF_NUM_REGS-1:0] reg_onehot(input logic [RF_ADDR_W-1:0] r);
        logic [RF_NUM_REGS-1:0] m;
        m    = '0;
        m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Small write-back request FIFO with per-entry visibility for hazard tracking.
// Latency: a push is visible at head the cycle after the push edge; pop takes effect on the edge.
// Backpressure: full blocks pushes (no pass-through even when popping); empty blocks pops.
//
// Ports: clk, rst (async active-low), flush (sync clear), push/push_req, pop,
//        full/empty, head (oldest entry), ent_valid/ent_reg (per-slot occupancy and register).
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               push,
    input  wb_req                              push_req,
    input  logic                               pop,
    output logic                               full,
    output logic                               empty,
    output wb_req                              head,
    output logic [DEPTH-1:0]                   ent_valid,
    output logic [DEPTH-1:0][RF_ADDR_W-1:0]    ent_reg
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_req             slots [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // In a circular buffer the write slot is occupied only when full, and the
    // read slot is free only when empty, so the valid bits double as flags.
    assign full    = vld[wr_ptr];
    assign empty   = !vld[rd_ptr];
    assign head    = slots[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign ent_valid = vld;
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign ent_reg[i] = slots[i].dst;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            vld    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // push and pop can never target the same slot: that would need
            // the FIFO to be simultaneously not full and not empty at wr==rd.
            if (do_push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by vld.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_req;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates ALU and MEM write-backs onto the single register-file write port.
// Latency: request accepted at edge N drives the write port after edge N+1; one write per cycle.
// Backpressure: x_ready = !x_full, independent of x_valid; MEM has priority with ALU anti-starvation.
//
// Ports: clk, rst (async active-low), flush (sync discard of buffered writes),
//        alu_valid/alu_ready/alu_reg/alu_data, mem_valid/mem_ready/mem_reg/mem_data,
//        writeReg/dstReg/dstData (registered RF write), pend_mask (hazard mask), busy.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [RF_ADDR_W-1:0]    alu_reg,
    input  logic [RF_DATA_W-1:0]    alu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [RF_ADDR_W-1:0]    mem_reg,
    input  logic [RF_DATA_W-1:0]    mem_data,
    output logic                    writeReg,
    output logic [RF_ADDR_W-1:0]    dstReg,
    output logic [RF_DATA_W-1:0]    dstData,
    output logic [RF_NUM_REGS-1:0]  pend_mask,
    output logic                    busy
);

    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic                             alu_full, alu_empty, mem_full, mem_empty;
    wb_req                            alu_head, mem_head;
    logic [DEPTH-1:0]                 alu_ent_valid, mem_ent_valid;
    logic [DEPTH-1:0][RF_ADDR_W-1:0]  alu_ent_reg, mem_ent_reg;
    logic                             alu_push, mem_push;
    logic                             grant_alu, grant_mem;
    logic [CNT_W-1:0]                 starve_cnt;

    assign alu_ready = !alu_full;
    assign mem_ready = !mem_full;
    assign alu_push  = alu_valid && !alu_full && !flush;
    assign mem_push  = mem_valid && !mem_full && !flush;

    // MEM normally wins; after STARVE_MAX consecutive losses the ALU gets one turn.
    assign grant_alu = !flush && !alu_empty &&
                       (mem_empty || (starve_cnt == CNT_W'(STARVE_MAX)));
    assign grant_mem = !flush && !mem_empty && !grant_alu;

    rf_wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (alu_push),
        .push_req  ({alu_reg, alu_data}),
        .pop       (grant_alu),
        .full      (alu_full),
        .empty     (alu_empty),
        .head      (alu_head),
        .ent_valid (alu_ent_valid),
        .ent_reg   (alu_ent_reg)
    );

    rf_wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (mem_push),
        .push_req  ({mem_reg, mem_data}),
        .pop       (grant_mem),
        .full      (mem_full),
        .empty     (mem_empty),
        .head      (mem_head),
        .ent_valid (mem_ent_valid),
        .ent_reg   (mem_ent_reg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            writeReg   <= 1'b0;
            dstReg     <= '0;
            dstData    <= '0;
            starve_cnt <= '0;
        end else if (flush) begin
            // The write already on the port is captured by the RF on this edge.
            writeReg   <= 1'b0;
            starve_cnt <= '0;
        end else begin
            writeReg <= grant_alu || grant_mem;
            if (grant_alu) begin
                dstReg  <= alu_head.dst;
                dstData <= alu_head.data;
            end else if (grant_mem) begin
                dstReg  <= mem_head.dst;
                dstData <= mem_head.data;
            end

            if (alu_empty || grant_alu) begin
                starve_cnt <= '0;
            end else if (grant_mem) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    // Hazard mask: every buffered entry plus the write currently on the port.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_ent_valid[i]) pend_mask = pend_mask | reg_onehot(alu_ent_reg[i]);
            if (mem_ent_valid[i]) pend_mask = pend_mask | reg_onehot(mem_ent_reg[i]);
        end
        if (writeReg) pend_mask = pend_mask | reg_onehot(dstReg);
    end

    assign busy = |pend_mask;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [3:0]  alu_reg, mem_reg, dstReg;
    logic [15:0] alu_data, mem_data, dstData, pend_mask;
    logic        writeReg, busy;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_reg   (alu_reg),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_reg   (mem_reg),
        .mem_data  (mem_data),
        .writeReg  (writeReg),
        .dstReg    (dstReg),
        .dstData   (dstData),
        .pend_mask (pend_mask),
        .busy      (busy)
    );

    typedef struct packed {
        logic [3:0]  r;
        logic [15:0] d;
    } ent_t;

    // Reference model: producer queues, the write on the port, ALU loss streak.
    ent_t        aq[$];
    ent_t        mq[$];
    ent_t        exp_q[$];
    int          losses;
    bit          m_wr;
    logic [3:0]  m_dst;
    logic [15:0] m_dat;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_mask();
        logic [15:0] m;
        m = '0;
        foreach (aq[i]) m[aq[i].r] = 1'b1;
        foreach (mq[i]) m[mq[i].r] = 1'b1;
        if (m_wr) m[m_dst] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        aq.delete();
        mq.delete();
        exp_q.delete();
        losses = 0;
        m_wr   = 1'b0;
        m_dst  = '0;
        m_dat  = '0;
    endtask

    task automatic check_state();
        chk("alu_ready", 32'(alu_ready), 32'(aq.size() < DEPTH));
        chk("mem_ready", 32'(mem_ready), 32'(mq.size() < DEPTH));
        chk("pend_mask", 32'(pend_mask), 32'(model_mask()));
        chk("busy",      32'(busy),      32'(model_mask() != 16'h0));
        chk("writeReg",  32'(writeReg),  32'(m_wr));
        chk("dstReg",    32'(dstReg),    32'(m_dst));
        chk("dstData",   32'(dstData),   32'(m_dat));
    endtask

    // One clock cycle: entered and left just after a falling edge.
    task automatic step(input bit av, input logic [3:0] ar, input logic [15:0] ad,
                        input bit mv, input logic [3:0] mr, input logic [15:0] md,
                        input bit fl);
        bit   acc_a, acc_m;
        ent_t g, e;
        check_state();
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        flush     = fl;
        acc_a = av && (aq.size() < DEPTH) && !fl;
        acc_m = mv && (mq.size() < DEPTH) && !fl;
        if (fl) begin
            aq.delete();
            mq.delete();
            m_wr   = 1'b0;
            losses = 0;
        end else begin
            m_wr = 1'b0;
            if (aq.size() > 0 && (mq.size() == 0 || losses == STARVE_MAX)) begin
                g = aq.pop_front();
                losses = 0;
                m_wr = 1'b1;
            end else if (mq.size() > 0) begin
                g = mq.pop_front();
                losses = (aq.size() > 0) ? losses + 1 : 0;
                m_wr = 1'b1;
            end else begin
                losses = 0;
            end
            if (m_wr) begin
                m_dst = g.r;
                m_dat = g.d;
                exp_q.push_back(g);
            end
            if (acc_a) begin e.r = ar; e.d = ad; aq.push_back(e); end
            if (acc_m) begin e.r = mr; e.d = md; mq.push_back(e); end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0);
    endtask

    // Scoreboard monitor: every write on the port must be the next expected one.
    initial begin
        ent_t e;
        forever begin
            @(posedge clk);
            #1;
            if (writeReg === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_write: got reg %0h data %0h, required no write (t=%0t)",
                             dstReg, dstData, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_reg",  32'(dstReg),  32'(e.r));
                    chk("wr_data", 32'(dstData), 32'(e.d));
                end
            end
        end
    end

    initial begin
        int pushed;
        bit acc;
        rst = 1'b0; flush = 1'b0;
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
        model_reset();
        #1;
        check_state();
        @(negedge clk);
        rst = 1'b1;

        // Single ALU write: visible on the port one cycle after acceptance.
        step(1'b1, 4'd3, 16'hBEEF, 1'b0, 4'h0, 16'h0, 1'b0);
        chk("single_pend_queued", 32'(pend_mask), 32'h0008);
        chk("single_not_yet",     32'(writeReg),  32'h0);
        idle(1);
        chk("single_wr",   32'(writeReg), 32'h1);
        chk("single_reg",  32'(dstReg),   32'h3);
        chk("single_data", 32'(dstData),  32'hBEEF);
        chk("single_pend", 32'(pend_mask), 32'h0008);
        idle(1);
        chk("single_pend_clear", 32'(pend_mask), 32'h0);
        chk("idle_wr",           32'(writeReg),  32'h0);
        chk("idle_reg_hold",     32'(dstReg),    32'h3);

        // MEM-only push into empty FIFOs issues exactly one cycle later.
        step(1'b0, 4'h0, 16'h0, 1'b1, 4'hC, 16'h1234, 1'b0);
        chk("mem_only_not_yet", 32'(writeReg), 32'h0);
        idle(1);
        chk("mem_only_wr",  32'(writeReg), 32'h1);
        chk("mem_only_reg", 32'(dstReg),   32'hC);
        idle(2);

        // Starvation: both valid every cycle -> MEM,MEM,MEM,ALU on the port.
        for (int i = 0; i < 13; i++) begin
            step(1'b1, 4'(i), {4'hA, 12'(i)}, 1'b1, 4'(i + 7), {4'h5, 12'(i)}, 1'b0);
            if (i >= 1) begin
                chk("starve_wr",  32'(writeReg), 32'h1);
                chk("starve_src", 32'(dstData[15:12] == 4'hA), 32'(((i - 1) % 4) == 3));
            end
        end
        idle(6);

        // Backpressure: MEM always valid, ALU pushes four writes.
        pushed = 0;
        for (int c = 0; c < 40 && pushed < 4; c++) begin
            acc = alu_ready;
            step(1'b1, 4'(pushed + 1), 16'hC0D0 + 16'(pushed), 1'b1, 4'hE, 16'(c), 1'b0);
            if (acc) begin
                pushed++;
                if (pushed == 2) chk("alu_ready_after_2nd", 32'(alu_ready), 32'h0);
            end
        end
        chk("alu_pushes", 32'(pushed), 32'd4);
        idle(6);

        // Flush with reg 5 / reg 9 buffered; pushes during flush are dropped too.
        step(1'b1, 4'd5, 16'h5555, 1'b1, 4'd9, 16'h9999, 1'b0);
        step(1'b1, 4'd5, 16'h5556, 1'b1, 4'd9, 16'h999A, 1'b1);
        chk("flush_pend", 32'(pend_mask), 32'h0);
        chk("flush_wr",   32'(writeReg),  32'h0);
        idle(3);

        // Reset mid-operation: ALU full, MEM holding, a write on the port.
        for (int i = 0; i < 3; i++)
            step(1'b1, 4'd1, 16'h1000 + 16'(i), 1'b1, 4'd2, 16'h2000 + 16'(i), 1'b0);
        chk("pre_reset_wr", 32'(writeReg), 32'h1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_wr",        32'(writeReg),  32'h0);
        chk("rst_pend",      32'(pend_mask), 32'h0);
        chk("rst_alu_ready", 32'(alu_ready), 32'h1);
        chk("rst_mem_ready", 32'(mem_ready), 32'h1);
        chk("rst_busy",      32'(busy),      32'h0);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(4);

        // Randomized traffic with occasional flushes.
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom), 16'($urandom),
                 $urandom_range(0, 3) != 0, 4'($urandom), 16'($urandom),
                 $urandom_range(0, 40) == 0);
        end
        idle(8);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
